// File: rtl/fma_operand_queue_pkg.sv
// Shared constants and entry sizing for the fpfma operand queue.
// Default widths, op/rounding encodings and the packed entry width.
package fma_operand_queue_pkg;

  localparam int unsigned FMA_WIDTH     = 32;
  localparam int unsigned FMA_EXP_WIDTH = 8;
  localparam int unsigned FMA_SIG_WIDTH = 23;
  localparam int unsigned FMA_TAG_WIDTH = 4;
  localparam int unsigned FMA_DEPTH     = 4;

  localparam logic FMA_OP_ADD = 1'b0;
  localparam logic FMA_OP_SUB = 1'b1;

  localparam logic [1:0] RND_RZ   = 2'b00;
  localparam logic [1:0] RND_RN   = 2'b01;
  localparam logic [1:0] RND_PINF = 2'b10;
  localparam logic [1:0] RND_NINF = 2'b11;

  // Stored entry is {A, B, C', rnd, tag}
  function automatic int unsigned entry_w(input int unsigned width, input int unsigned tag_width);
    return 3 * width + 2 + tag_width;
  endfunction

  localparam int unsigned FMA_ENTRY_W = entry_w(FMA_WIDTH, FMA_TAG_WIDTH);

endpackage

// File: rtl/fma_queue_mem.sv
// Entry storage for the operand queue: synchronous write, combinational read.
module fma_queue_mem
  import fma_operand_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = FMA_DEPTH,
  parameter int unsigned ENTRY_W = FMA_ENTRY_W
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [ENTRY_W-1:0]         rd_data_c
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/fma_operand_queue.sv
// In-order operand queue feeding fpfma; folds the add/sub op into C's sign
// and presents the head entry from flops so the datapath sees stable inputs.
module fma_operand_queue
  import fma_operand_queue_pkg::*;
#(
  parameter int unsigned WIDTH     = FMA_WIDTH,
  parameter int unsigned DEPTH     = FMA_DEPTH,
  parameter int unsigned TAG_WIDTH = FMA_TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH-1:0]         in_c,
  input  logic                     in_op,
  input  logic [1:0]               in_rnd,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [WIDTH-1:0]         out_c,
  output logic [1:0]               out_rnd,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = entry_w(WIDTH, TAG_WIDTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fma_operand_queue: DEPTH must be a power of 2 and at least 2");
  end

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_next_c;
  logic               push_c;
  logic               pop_c;
  logic               c_sign_c;
  logic [CNT_W-1:0]   count_next_c;
  logic [ENTRY_W-1:0] in_entry_c;
  logic [ENTRY_W-1:0] mem_rd_c;
  logic [ENTRY_W-1:0] head;

  // Subtract is folded into C's sign for every encoding, NaN and Inf included
  assign c_sign_c   = (in_op == FMA_OP_SUB) ? ~in_c[WIDTH-1] : in_c[WIDTH-1];
  assign in_entry_c = {in_a, in_b, c_sign_c, in_c[WIDTH-2:0], in_rnd, in_tag};

  // Flush suppresses both handshakes; in_ready is a flop so full blocks pushes
  assign push_c = in_valid & in_ready & ~flush;
  assign pop_c  = out_valid & out_ready & ~flush;

  assign rd_next_c    = rd_ptr + PTR_W'(1);
  assign count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);

  fma_queue_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk       (clk),
    .we        (push_c),
    .wr_addr   (wr_ptr),
    .wr_data   (in_entry_c),
    .rd_addr   (rd_next_c),
    .rd_data_c (mem_rd_c)
  );

  // Pointers, occupancy and the head output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      head      <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_next_c;
      end
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
      in_ready  <= (count_next_c < CNT_W'(DEPTH));
      // Next head comes from storage if one is queued behind it, else from the push
      if (pop_c && count > CNT_W'(1)) begin
        head <= mem_rd_c;
      end else if (push_c && (count == '0 || (pop_c && count == CNT_W'(1)))) begin
        head <= in_entry_c;
      end
    end
  end

  assign out_a   = head[ENTRY_W-1 -: WIDTH];
  assign out_b   = head[ENTRY_W-1-WIDTH -: WIDTH];
  assign out_c   = head[2+TAG_WIDTH +: WIDTH];
  assign out_rnd = head[TAG_WIDTH +: 2];
  assign out_tag = head[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_fma_operand_queue.sv
// Self-checking bench for fma_operand_queue: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_fma_operand_queue;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TAG_WIDTH = 4;
  localparam int unsigned CNT_W     = 3;

  typedef struct {
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic                 op;
    logic [1:0]           rnd;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_valid, in_ready, in_op, out_valid, out_ready;
  logic [WIDTH-1:0]     in_a, in_b, in_c, out_a, out_b, out_c;
  logic [1:0]           in_rnd, out_rnd;
  logic [TAG_WIDTH-1:0] in_tag, out_tag;
  logic [CNT_W-1:0]     count;

  req_t                 model_q[$];
  logic [TAG_WIDTH-1:0] issued[$];
  int                   n_assert = 0;
  int                   n_fail   = 0;

  always #5 clk = ~clk;

  fma_operand_queue #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_op     (in_op),
    .in_rnd    (in_rnd),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_rnd   (out_rnd),
    .out_tag   (out_tag),
    .count     (count)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [TAG_WIDTH-1:0] tag);
    req_t r;
    r.a   = $urandom;
    r.b   = $urandom;
    r.c   = $urandom;
    r.op  = 1'($urandom_range(0, 1));
    r.rnd = 2'($urandom_range(0, 3));
    r.tag = tag;
    return r;
  endfunction

  // Model view: C seen downstream is C with its sign flipped for subtract
  function automatic logic [WIDTH-1:0] eff_c(input req_t r);
    return r.op ? (r.c ^ 32'h8000_0000) : r.c;
  endfunction

  task automatic check_model();
    chk("count", 64'(count), 64'(model_q.size()));
    chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
    if (model_q.size() > 0) begin
      chk("head_a", 64'(out_a), 64'(model_q[0].a));
      chk("head_b", 64'(out_b), 64'(model_q[0].b));
      chk("head_c", 64'(out_c), 64'(eff_c(model_q[0])));
      chk("head_rnd", 64'(out_rnd), 64'(model_q[0].rnd));
      chk("head_tag", 64'(out_tag), 64'(model_q[0].tag));
    end
  endtask

  task automatic step(input logic v, input req_t r, input logic ordy, input logic fl, input logic rs);
    bit do_push, do_pop;
    in_valid  = v;
    in_a      = r.a;
    in_b      = r.b;
    in_c      = r.c;
    in_op     = r.op;
    in_rnd    = r.rnd;
    in_tag    = r.tag;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    do_push = v && (model_q.size() < DEPTH) && !fl && !rs;
    do_pop  = (model_q.size() > 0) && ordy && !fl && !rs;
    if (!rs && !fl && out_valid === 1'b1 && ordy) issued.push_back(out_tag);
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(r);
    end
    #1;
    check_model();
  endtask

  initial begin
    req_t r;
    req_t idle;
    bit   saw7;
    idle = '{a: '0, b: '0, c: '0, op: 1'b0, rnd: 2'b00, tag: '0};

    // Reset
    step(1'b0, idle, 1'b0, 1'b0, 1'b1);
    step(1'b0, idle, 1'b0, 1'b0, 1'b1);
    chk("rst_out_a", 64'(out_a), 64'h0);
    chk("rst_out_b", 64'(out_b), 64'h0);
    chk("rst_out_c", 64'(out_c), 64'h0);
    chk("rst_out_rnd", 64'(out_rnd), 64'h0);
    chk("rst_out_tag", 64'(out_tag), 64'h0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Basic issue
    r = '{a: 32'h3F80_0000, b: 32'h4000_0000, c: 32'h4040_0000, op: 1'b0, rnd: 2'b01, tag: 4'd5};
    step(1'b1, r, 1'b0, 1'b0, 1'b0);
    chk("basic_valid", 64'(out_valid), 64'h1);
    chk("basic_a", 64'(out_a), 64'h3F80_0000);
    chk("basic_b", 64'(out_b), 64'h4000_0000);
    chk("basic_c", 64'(out_c), 64'h4040_0000);
    chk("basic_rnd", 64'(out_rnd), 64'h1);
    chk("basic_tag", 64'(out_tag), 64'h5);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("basic_drain_count", 64'(count), 64'h0);

    // Subtract transform, including a NaN addend
    r = mk(4'd1); r.c = 32'h4040_0000; r.op = 1'b1;
    step(1'b1, r, 1'b0, 1'b0, 1'b0);
    chk("sub_c0", 64'(out_c), 64'hC040_0000);
    r = mk(4'd2); r.c = 32'hFFC0_0000; r.op = 1'b1;
    step(1'b1, r, 1'b0, 1'b0, 1'b0);
    chk("sub_c0_held", 64'(out_c), 64'hC040_0000);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    chk("sub_c1", 64'(out_c), 64'h7FC0_0000);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) step(1'b1, mk(TAG_WIDTH'(i)), 1'b0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    step(1'b1, mk(4'd9), 1'b0, 1'b0, 1'b0);
    chk("full_ignored_count", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 64'(out_tag), 64'(i));
      step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 64'(out_valid), 64'h0);

    // Full with simultaneous push attempt and pop, then steady push+pop wrap
    for (int i = 1; i <= 4; i++) step(1'b1, mk(TAG_WIDTH'(i)), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(4'd10), 1'b1, 1'b0, 1'b0);
    chk("full_pop_count", 64'(count), 64'd3);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(4'd11), 1'b1, 1'b0, 1'b0);
    chk("pushpop_count", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++) step(1'b1, mk(TAG_WIDTH'(i)), 1'b1, 1'b0, 1'b0);
    chk("wrap_count", 64'(count), 64'd2);
    for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 1'b0, 1'b0);

    // Flush with a coincident push
    issued.delete();
    for (int i = 1; i <= 3; i++) step(1'b1, mk(TAG_WIDTH'(i)), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(4'd7), 1'b0, 1'b1, 1'b0);
    chk("flush_count", 64'(count), 64'h0);
    chk("flush_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, 1'b0);
    saw7 = 1'b0;
    foreach (issued[i]) if (issued[i] == 4'd7) saw7 = 1'b1;
    chk("flush_tag7_dropped", 64'(saw7), 64'h0);

    // Reset mid-stream
    for (int i = 1; i <= 3; i++) step(1'b1, mk(TAG_WIDTH'(i + 4)), 1'b0, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0, 1'b1);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_a", 64'(out_a), 64'h0);
    chk("midrst_count", 64'(count), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);
    step(1'b1, mk(4'd2), 1'b0, 1'b0, 1'b0);
    chk("midrst_push_tag", 64'(out_tag), 64'h2);
    chk("midrst_push_valid", 64'(out_valid), 64'h1);
    step(1'b0, idle, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), mk(TAG_WIDTH'($urandom)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, idle, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
